approx_mac_sequencer: RTL and testbench

Sequential multiply-accumulate controller that shares one reduced-width (OSFM_BITWIDTH_I × OSFM_BITWIDTH_I) unsigned multiplier across a stream of BITWIDTH-bit operand pairs for a DNN dot product. For each operand it derives `shift_possible`, reduces the operand through two Inputshifter instances, and rescales the narrow product by the truncated shift. It then accumulates LENGTH products and returns the sum over a valid/ready handshake. It sits between the layer operand fetch logic and the output feature-map writer.

---
 rtl/approx_mac_sequencer_if.sv | 28 ++
 rtl/approx_mac_sequencer.sv | 125 ++++++++++++
 tb/tb_approx_mac_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/approx_mac_sequencer_if.sv
// Handshake bundle between operand fetch, the MAC sequencer and the OFM writer.
interface approx_mac_sequencer_if #(
    parameter int BITWIDTH = 16,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 16
);
    logic                start;
    logic [LEN_W-1:0]    length;
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    result;
    logic [LEN_W:0]      approx_count;
    logic                busy;

    modport master (
        output start, length, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, approx_count, busy
    );

    modport slave (
        input  start, length, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, approx_count, busy
    );
endinterface

// File: rtl/approx_mac_sequencer.sv
// Approximate MAC sequencer: reduced-width multiply with shift rescale,
// accumulating a dot product over a valid/ready operand stream.
module approx_mac_sequencer #(
    parameter int BITWIDTH        = 16,
    parameter int OSFM_BITWIDTH_I = 8,
    parameter int SHIFTDISTANCE   = BITWIDTH - OSFM_BITWIDTH_I,
    parameter int ACC_W           = 32,
    parameter int LEN_W           = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    approx_mac_sequencer_if.slave       bus
);
    localparam int TW = (2 * BITWIDTH > ACC_W) ? 2 * BITWIDTH : ACC_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]           remaining;
    logic [ACC_W-1:0]           acc;
    logic [LEN_W:0]             approx_cnt;
    logic                       s1_valid;
    logic [OSFM_BITWIDTH_I-1:0] s1_ra, s1_rb;
    logic [1:0]                 s1_n;

    logic                       accept;
    logic                       sp_a, sp_b;
    logic [OSFM_BITWIDTH_I-1:0] ra, rb;
    logic [1:0]                 n_in;
    logic [TW-1:0]              prod, term;

    // Inputshifter: low bits pass through, otherwise keep the top bits
    // and fold the first dropped bit into the LSB as a cheap round-up.
    function automatic logic [OSFM_BITWIDTH_I-1:0] inputshifter(
        input logic [BITWIDTH-1:0] x
    );
        if (x[BITWIDTH-1:OSFM_BITWIDTH_I] == '0)
            return x[OSFM_BITWIDTH_I-1:0];
        return {x[BITWIDTH-1:SHIFTDISTANCE+1],
                x[SHIFTDISTANCE] | x[SHIFTDISTANCE-1]};
    endfunction

    assign sp_a   = (bus.a[BITWIDTH-1:OSFM_BITWIDTH_I] == '0);
    assign sp_b   = (bus.b[BITWIDTH-1:OSFM_BITWIDTH_I] == '0);
    assign ra     = inputshifter(bus.a);
    assign rb     = inputshifter(bus.b);
    assign n_in   = 2'(!sp_a) + 2'(!sp_b);
    assign accept = (state == RUN) && bus.in_valid;

    always_comb begin
        prod = TW'(s1_ra) * TW'(s1_rb);
        unique case (s1_n)
            2'd0:    term = prod;
            2'd1:    term = prod << SHIFTDISTANCE;
            default: term = prod << (2 * SHIFTDISTANCE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (bus.start)
                    state_nxt = (bus.length == '0) ? DRAIN : RUN;
            RUN:
                if (accept && remaining == LEN_W'(1))
                    state_nxt = DRAIN;
            DRAIN:
                state_nxt = DONE;
            DONE:
                if (bus.out_ready)
                    state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            acc        <= '0;
            approx_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_ra      <= '0;
            s1_rb      <= '0;
            s1_n       <= '0;
        end else if (state == IDLE && bus.start) begin
            remaining  <= bus.length;
            acc        <= '0;
            approx_cnt <= '0;
            s1_valid   <= 1'b0;
        end else begin
            // S1 retires on the edge after its pair was accepted
            if (s1_valid)
                acc <= acc + term[ACC_W-1:0];
            s1_valid <= accept;
            if (accept) begin
                s1_ra      <= ra;
                s1_rb      <= rb;
                s1_n       <= n_in;
                remaining  <= remaining - LEN_W'(1);
                approx_cnt <= approx_cnt + (LEN_W+1)'(n_in);
            end
        end
    end

    assign bus.in_ready     = (state == RUN);
    assign bus.out_valid    = (state == DONE);
    assign bus.busy         = (state != IDLE);
    assign bus.result       = acc;
    assign bus.approx_count = approx_cnt;
endmodule

// File: tb/tb_approx_mac_sequencer.sv
// Randomized bench for approx_mac_sequencer against an arithmetic model.
module tb_approx_mac_sequencer;
    localparam int BW = 16;
    localparam int OW = 8;
    localparam int SD = BW - OW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    approx_mac_sequencer_if #(.BITWIDTH(16), .ACC_W(32), .LEN_W(16)) bus();

    approx_mac_sequencer #(
        .BITWIDTH(16), .OSFM_BITWIDTH_I(8), .ACC_W(32), .LEN_W(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint reduce(input longint x);
        if (x < (longint'(1) << OW))
            return x;
        return (x >> SD) | ((x >> (SD - 1)) & 1);
    endfunction

    function automatic logic [31:0] model_sum();
        longint s = 0;
        for (int i = 0; i < qa.size(); i++) begin
            int n = 0;
            if (qa[i] >= 16'd256) n++;
            if (qb[i] >= 16'd256) n++;
            s += (reduce(qa[i]) * reduce(qb[i])) * (longint'(1) << (SD * n));
        end
        return s[31:0];
    endfunction

    function automatic logic [16:0] model_cnt();
        int c = 0;
        for (int i = 0; i < qa.size(); i++) begin
            if (qa[i] >= 16'd256) c++;
            if (qb[i] >= 16'd256) c++;
        end
        return 17'(c);
    endfunction

    function automatic logic [15:0] rand_op();
        unique case ($urandom_range(0, 2))
            0: return 16'($urandom_range(0, 255));
            1: return 16'($urandom_range(256, 65535));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_job(input int len, input logic [31:0] exp_res,
                           input logic [16:0] exp_cnt, input bit gaps,
                           input int hold);
        int idx = 0;
        int cyc = 0;
        bit took;
        @(negedge clk);
        bus.start = 1'b1;
        bus.length = 16'(len);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        while (idx < len && cyc < 2000) begin
            bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.a = qa[idx];
            bus.b = qb[idx];
            #1;
            took = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (took) idx++;
            cyc++;
        end
        if (idx < len)
            check("accept_timeout", 64'(idx), 64'(len));
        // DRAIN cycle: stray pair and start must both be ignored
        bus.in_valid = 1'b1;
        bus.a = 16'($urandom);
        bus.start = 1'b1;
        #1;
        check("drain_in_ready", bus.in_ready, 0);
        check("drain_out_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        check("out_valid_latency", bus.out_valid, 1);
        check("result", bus.result, exp_res);
        check("approx_count", bus.approx_count, exp_cnt);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.result, exp_res);
        end
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        check("idle_after_hs", bus.busy, 0);
        check("valid_after_hs", bus.out_valid, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.length = '0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        rst_n = 1'b1;

        qa = '{16'h0003, 16'h0004};
        qb = '{16'h0005, 16'h0010};
        run_job(2, 32'h4F, 17'd0, 1'b0, 0);
        qa = '{16'h1234};
        qb = '{16'h0002};
        run_job(1, 32'h2400, 17'd1, 1'b0, 1);
        qa = '{16'h0180};
        qb = '{16'h0180};
        run_job(1, 32'h10000, 17'd2, 1'b0, 0);
        qa = '{16'h0010, 16'h0300, 16'h0007};
        qb = '{16'h0020, 16'h0002, 16'hFFFF};
        run_job(3, model_sum(), model_cnt(), 1'b1, 5);
        qa.delete();
        qb.delete();
        run_job(0, 32'h0, 17'd0, 1'b0, 2);

        for (int j = 0; j < 20; j++) begin
            int len = $urandom_range(1, 8);
            qa.delete();
            qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back(rand_op());
                qb.push_back(rand_op());
            end
            run_job(len, model_sum(), model_cnt(), 1'($urandom),
                    $urandom_range(0, 4));
        end

        // abort mid-RUN after two accepts
        @(negedge clk);
        bus.start = 1'b1;
        bus.length = 16'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.result, 0);
        check("abort_count", bus.approx_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        qa = '{16'd2};
        qb = '{16'd3};
        run_job(1, 32'd6, 17'd0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
